// File: rtl/gpr_port_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_port_arbiter
//   Owns the single GPR write port and the debug read path of reg_file.
//   Core writeback always wins when it is not stalled. The UART loader and the
//   debug module each have a one-entry holding register. They share the free
//   slots round-robin. A starvation counter forces a one-cycle core stall when a
//   held request has waited STARVE_LIMIT cycles. Debug accesses complete with a
//   registered, handshaked response that carries an error flag.
//
//   Configuration macro: GPR_X0_WRITE_FILTER_EN
//     defined   - grants to index 0 complete normally, but gpr_wr_en_o stays 0
//     undefined - writes to x0 are forwarded to reg_file
//
// Ports
//   reg_clk, reg_rst            clock, asynchronous active-high reset
//   core_wr_en_i/rd_i/wr_data_i core writeback request (highest priority)
//   core_stall_o                core must hold its pipeline this cycle
//   uart_valid_i/rd_i/data_i    UART load request; uart_ready_o accepts it
//   dbg_valid_i/write_i/addr_i/wdata_i  debug request; dbg_ready_o accepts it
//   dbg_resp_valid_o/ready_i    debug response handshake
//   dbg_rdata_o, dbg_err_o      debug response payload
//   gpr_wr_en_o/addr_o/data_o   reg_file write port
//   gpr_rd_addr_o, gpr_rd_data_i reg_file debug read port (combinational data)
// -----------------------------------------------------------------------------
module gpr_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                      reg_clk,
  input  logic                      reg_rst,
  input  logic                      core_wr_en_i,
  input  logic [GPR_ADDR_WIDTH-1:0] core_rd_i,
  input  logic [DATA_WIDTH-1:0]     core_wr_data_i,
  output logic                      core_stall_o,
  input  logic                      uart_valid_i,
  input  logic [GPR_ADDR_WIDTH-1:0] uart_rd_i,
  input  logic [DATA_WIDTH-1:0]     uart_data_i,
  output logic                      uart_ready_o,
  input  logic                      dbg_valid_i,
  input  logic                      dbg_write_i,
  input  logic [15:0]               dbg_addr_i,
  input  logic [DATA_WIDTH-1:0]     dbg_wdata_i,
  output logic                      dbg_ready_o,
  output logic                      dbg_resp_valid_o,
  input  logic                      dbg_resp_ready_i,
  output logic [DATA_WIDTH-1:0]     dbg_rdata_o,
  output logic                      dbg_err_o,
  output logic                      gpr_wr_en_o,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_wr_addr_o,
  output logic [DATA_WIDTH-1:0]     gpr_wr_data_o,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]     gpr_rd_data_i
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_RESP} dbg_state_t;

  dbg_state_t dbg_state_q, dbg_state_d;

  logic                      uart_full_q;
  logic [GPR_ADDR_WIDTH-1:0] uart_rd_q;
  logic [DATA_WIDTH-1:0]     uart_data_q;
  logic                      dbg_write_q;
  logic [GPR_ADDR_WIDTH-1:0] dbg_idx_q;
  logic [DATA_WIDTH-1:0]     dbg_wdata_q;
  logic [DATA_WIDTH-1:0]     dbg_rdata_q;
  logic                      dbg_err_q;
  logic                      rr_dbg_q;     // 0: UART has the next tie, 1: debug
  logic [CW-1:0]             starve_cnt_q;
  logic                      stall_q;

  logic uart_pend, dbg_pend, any_pend, slot;
  logic grant_uart, grant_dbg, uart_accept, dbg_accept;
  logic                      wr_en_raw;
  logic [GPR_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;

  // Only the address bits that decode GPR space are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dbg_addr_i[15:13], dbg_addr_i[11:GPR_ADDR_WIDTH]};

  assign uart_pend = uart_full_q;
  assign dbg_pend  = (dbg_state_q == D_WAIT) && dbg_write_q;
  assign any_pend  = uart_pend || dbg_pend;
  // A stalled core cycle is a slot, so the core path only wins when not stalled.
  assign slot      = !core_wr_en_i || stall_q;

  assign grant_uart = slot && uart_pend && (!dbg_pend || !rr_dbg_q);
  assign grant_dbg  = slot && dbg_pend  && (!uart_pend || rr_dbg_q);

  // Readies are forced low while reset is held so every output reads 0.
  assign uart_ready_o = !reg_rst && !uart_full_q;
  assign dbg_ready_o  = !reg_rst && (dbg_state_q == D_IDLE);
  assign uart_accept  = uart_valid_i && uart_ready_o;
  assign dbg_accept   = dbg_valid_i && dbg_ready_o;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_en_raw = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    if (!reg_rst) begin
      if (!slot) begin
        wr_en_raw = 1'b1;
        wr_addr   = core_rd_i;
        wr_data   = core_wr_data_i;
      end else if (grant_uart) begin
        wr_en_raw = 1'b1;
        wr_addr   = uart_rd_q;
        wr_data   = uart_data_q;
      end else if (grant_dbg) begin
        wr_en_raw = 1'b1;
        wr_addr   = dbg_idx_q;
        wr_data   = dbg_wdata_q;
      end
    end
  end

`ifdef GPR_X0_WRITE_FILTER_EN
  assign gpr_wr_en_o = wr_en_raw && (wr_addr != '0);
`else
  assign gpr_wr_en_o = wr_en_raw;
`endif
  assign gpr_wr_addr_o = wr_addr;
  assign gpr_wr_data_o = wr_data;

  assign core_stall_o     = stall_q;
  assign gpr_rd_addr_o    = (dbg_state_q == D_WAIT && !dbg_write_q) ? dbg_idx_q : '0;
  assign dbg_resp_valid_o = (dbg_state_q == D_RESP);
  assign dbg_rdata_o      = dbg_resp_valid_o ? dbg_rdata_q : '0;
  assign dbg_err_o        = dbg_resp_valid_o && dbg_err_q;

  // Debug FSM: next state.
  always_comb begin
    dbg_state_d = dbg_state_q;
    unique case (dbg_state_q)
      D_IDLE: if (dbg_accept) dbg_state_d = dbg_addr_i[12] ? D_WAIT : D_RESP;
      D_WAIT: if (!dbg_write_q || grant_dbg) dbg_state_d = D_RESP;
      D_RESP: if (dbg_resp_ready_i) dbg_state_d = D_IDLE;
      default: dbg_state_d = D_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) dbg_state_q <= D_IDLE;
    else         dbg_state_q <= dbg_state_d;
  end

  // NOTE: payload registers are reset as well; they are few, and it keeps
  // responses from carrying stale data across a reset.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      uart_full_q  <= 1'b0;
      uart_rd_q    <= '0;
      uart_data_q  <= '0;
      dbg_write_q  <= 1'b0;
      dbg_idx_q    <= '0;
      dbg_wdata_q  <= '0;
      dbg_rdata_q  <= '0;
      dbg_err_q    <= 1'b0;
      rr_dbg_q     <= 1'b0;
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      if (grant_uart) begin
        uart_full_q <= 1'b0;
      end else if (uart_accept) begin
        uart_full_q <= 1'b1;
        uart_rd_q   <= uart_rd_i;
        uart_data_q <= uart_data_i;
      end

      if (dbg_accept) begin
        dbg_write_q <= dbg_write_i;
        dbg_idx_q   <= dbg_addr_i[GPR_ADDR_WIDTH-1:0];
        dbg_wdata_q <= dbg_wdata_i;
        dbg_err_q   <= !dbg_addr_i[12];
        dbg_rdata_q <= '0;
      end else if (dbg_state_q == D_WAIT && !dbg_write_q) begin
        // x0 always reads as zero, whatever reg_file drives.
        dbg_rdata_q <= (dbg_idx_q == '0) ? '0 : gpr_rd_data_i;
      end

      if (grant_uart)     rr_dbg_q <= 1'b1;
      else if (grant_dbg) rr_dbg_q <= 1'b0;

      // The stall fires on the cycle after the counter sits at its limit with
      // no slot; the stall cycle itself is a slot, so the pulse is one cycle.
      if (grant_uart || grant_dbg) begin
        starve_cnt_q <= '0;
        stall_q      <= 1'b0;
      end else if (any_pend && !slot) begin
        if (starve_cnt_q == CW'(STARVE_LIMIT - 1)) stall_q <= 1'b1;
        else starve_cnt_q <= starve_cnt_q + 1'b1;
      end else begin
        stall_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpr_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpr_port_arbiter
//   Self-checking bench for gpr_port_arbiter. A small reg_file model sits on the
//   write/read ports; its x0 storage returns junk so the x0 read masking shows.
//   Expected GPR writes and debug responses are queued when stimulus is driven
//   and compared in order by two monitors; each test task also checks cycle
//   timing inline.
// -----------------------------------------------------------------------------
module tb_gpr_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SL = 8;
`ifdef GPR_X0_WRITE_FILTER_EN
  localparam logic X0_WR_EN = 1'b0;
`else
  localparam logic X0_WR_EN = 1'b1;
`endif

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [DW-1:0] rdata; logic err; } resp_t;

  logic          reg_clk, reg_rst;
  logic          core_wr_en_i;
  logic [AW-1:0] core_rd_i;
  logic [DW-1:0] core_wr_data_i;
  logic          core_stall_o;
  logic          uart_valid_i;
  logic [AW-1:0] uart_rd_i;
  logic [DW-1:0] uart_data_i;
  logic          uart_ready_o;
  logic          dbg_valid_i, dbg_write_i;
  logic [15:0]   dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;
  logic          dbg_ready_o, dbg_resp_valid_o, dbg_resp_ready_i;
  logic [DW-1:0] dbg_rdata_o;
  logic          dbg_err_o;
  logic          gpr_wr_en_o;
  logic [AW-1:0] gpr_wr_addr_o;
  logic [DW-1:0] gpr_wr_data_o;
  logic [AW-1:0] gpr_rd_addr_o;
  logic [DW-1:0] gpr_rd_data_i;

  int n_checks = 0;
  int n_fail   = 0;
  wr_t   exp_wr[$];
  resp_t exp_resp[$];
  wr_t   mon_w;
  resp_t mon_r;

  logic [DW-1:0] regs [32];

  gpr_port_arbiter #(.DATA_WIDTH(DW), .GPR_ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .reg_clk(reg_clk), .reg_rst(reg_rst),
    .core_wr_en_i(core_wr_en_i), .core_rd_i(core_rd_i), .core_wr_data_i(core_wr_data_i),
    .core_stall_o(core_stall_o),
    .uart_valid_i(uart_valid_i), .uart_rd_i(uart_rd_i), .uart_data_i(uart_data_i),
    .uart_ready_o(uart_ready_o),
    .dbg_valid_i(dbg_valid_i), .dbg_write_i(dbg_write_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ready_o(dbg_ready_o),
    .dbg_resp_valid_o(dbg_resp_valid_o), .dbg_resp_ready_i(dbg_resp_ready_i),
    .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
    .gpr_wr_en_o(gpr_wr_en_o), .gpr_wr_addr_o(gpr_wr_addr_o), .gpr_wr_data_o(gpr_wr_data_o),
    .gpr_rd_addr_o(gpr_rd_addr_o), .gpr_rd_data_i(gpr_rd_data_i)
  );

  initial reg_clk = 1'b0;
  always #5 reg_clk = ~reg_clk;

  // reg_file model: synchronous write, combinational read, junk in raw x0.
  always @(posedge reg_clk) if (gpr_wr_en_o) regs[gpr_wr_addr_o] <= gpr_wr_data_o;
  assign gpr_rd_data_i = (gpr_rd_addr_o == '0) ? 32'hBAD0_0BAD : regs[gpr_rd_addr_o];

  // Write-port monitor.
  always @(negedge reg_clk) begin
    if (gpr_wr_en_o === 1'b1) begin
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write at %0t",
                 gpr_wr_addr_o, gpr_wr_data_o, $time);
      end else begin
        mon_w = exp_wr.pop_front();
        if ({gpr_wr_addr_o, gpr_wr_data_o} !== {mon_w.addr, mon_w.data}) begin
          n_fail++;
          $display("FAIL wr_order: got addr=%0d data=%h, expected addr=%0d data=%h at %0t",
                   gpr_wr_addr_o, gpr_wr_data_o, mon_w.addr, mon_w.data, $time);
        end
      end
    end
  end

  // Debug response monitor: compares on each response handshake.
  always @(negedge reg_clk) begin
    if (dbg_resp_valid_o === 1'b1 && dbg_resp_ready_i === 1'b1) begin
      n_checks++;
      if (exp_resp.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got rdata=%h err=%b at %0t", dbg_rdata_o, dbg_err_o, $time);
      end else begin
        mon_r = exp_resp.pop_front();
        if ({dbg_rdata_o, dbg_err_o} !== {mon_r.rdata, mon_r.err}) begin
          n_fail++;
          $display("FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b at %0t",
                   dbg_rdata_o, dbg_err_o, mon_r.rdata, mon_r.err, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic do_reset();
    reg_rst = 1'b1;
    cyc();
    cyc();
    reg_rst = 1'b0;
  endtask

  task automatic test_reset();
    reg_rst = 1'b1;
    core_wr_en_i = 1'b1; core_rd_i = 5'd9; core_wr_data_i = 32'h1234;
    #1;
    n_checks++;
    if ({uart_ready_o, dbg_ready_o, core_stall_o, gpr_wr_en_o, dbg_resp_valid_o, dbg_err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 000000",
               {uart_ready_o, dbg_ready_o, core_stall_o, gpr_wr_en_o, dbg_resp_valid_o, dbg_err_o});
    end
    n_checks++;
    if ({gpr_wr_addr_o, gpr_wr_data_o, gpr_rd_addr_o, dbg_rdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got wa=%0d wd=%h ra=%0d rd=%h, expected all 0",
               gpr_wr_addr_o, gpr_wr_data_o, gpr_rd_addr_o, dbg_rdata_o);
    end
    core_wr_en_i = 1'b0;
    cyc();
    reg_rst = 1'b0;
    #1;
    n_checks++;
    if ({uart_ready_o, dbg_ready_o, core_stall_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release: got ready/ready/stall=%b, expected 110",
               {uart_ready_o, dbg_ready_o, core_stall_o});
    end
  endtask

  task automatic test_starvation();
    do_reset();
    cyc();
    core_wr_en_i = 1'b1; core_rd_i = 5'd5; core_wr_data_i = 32'hA5;
    uart_valid_i = 1'b1; uart_rd_i = 5'd6; uart_data_i = 32'h11;
    exp_wr.push_back('{5'd5, 32'hA5});
    #1;
    n_checks++;
    if (uart_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL starve_accept: uart_ready got %b, expected 1", uart_ready_o);
    end
    // Cycle k counts from the first cycle the UART entry is held.
    for (int k = 0; k <= SL + 1; k++) begin
      cyc();
      uart_valid_i = 1'b0;
      if (k == SL) exp_wr.push_back('{5'd6, 32'h11});
      else         exp_wr.push_back('{5'd5, 32'hA5});
      #1;
      n_checks++;
      if (core_stall_o !== (k == SL)) begin
        n_fail++; $display("FAIL starve_stall k=%0d: got %b, expected %b", k, core_stall_o, k == SL);
      end
      n_checks++;
      if (uart_ready_o !== (k == SL + 1)) begin
        n_fail++; $display("FAIL starve_ready k=%0d: got %b, expected %b", k, uart_ready_o, k == SL + 1);
      end
    end
    cyc();
    core_wr_en_i = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    dbg_resp_ready_i = 1'b1;
    // Round 1: tie after reset goes to UART first.
    cyc();
    uart_valid_i = 1'b1; uart_rd_i = 5'd7; uart_data_i = 32'h22;
    dbg_valid_i = 1'b1; dbg_write_i = 1'b1; dbg_addr_i = 16'h1008; dbg_wdata_i = 32'h33;
    exp_wr.push_back('{5'd7, 32'h22});
    exp_wr.push_back('{5'd8, 32'h33});
    exp_resp.push_back('{32'h0, 1'b0});
    #1;
    n_checks++;
    if ({uart_ready_o, dbg_ready_o} !== 2'b11) begin
      n_fail++; $display("FAIL rr_accept: got %b, expected 11", {uart_ready_o, dbg_ready_o});
    end
    cyc(); uart_valid_i = 1'b0; dbg_valid_i = 1'b0;
    cyc(); #1;
    n_checks++;
    if ({uart_ready_o, dbg_resp_valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL rr_r1_c2: ready/resp got %b, expected 10", {uart_ready_o, dbg_resp_valid_o});
    end
    cyc(); #1;
    n_checks++;
    if (dbg_resp_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL rr_r1_resp: got %b, expected 1", dbg_resp_valid_o);
    end
    // Round 2: lone UART grant moves the pointer to debug.
    cyc();
    uart_valid_i = 1'b1; uart_rd_i = 5'd9; uart_data_i = 32'h44;
    exp_wr.push_back('{5'd9, 32'h44});
    cyc(); uart_valid_i = 1'b0;
    cyc();
    // Round 3: the next tie goes to debug first.
    cyc();
    uart_valid_i = 1'b1; uart_rd_i = 5'd11; uart_data_i = 32'h55;
    dbg_valid_i = 1'b1; dbg_write_i = 1'b1; dbg_addr_i = 16'h100C; dbg_wdata_i = 32'h66;
    exp_wr.push_back('{5'd12, 32'h66});
    exp_wr.push_back('{5'd11, 32'h55});
    exp_resp.push_back('{32'h0, 1'b0});
    cyc(); uart_valid_i = 1'b0; dbg_valid_i = 1'b0; #1;
    n_checks++;
    if ({uart_ready_o, dbg_resp_valid_o} !== 2'b00) begin
      n_fail++; $display("FAIL rr_r3_c1: ready/resp got %b, expected 00", {uart_ready_o, dbg_resp_valid_o});
    end
    cyc(); #1;
    n_checks++;
    if ({uart_ready_o, dbg_resp_valid_o} !== 2'b01) begin
      n_fail++; $display("FAIL rr_r3_c2: ready/resp got %b, expected 01", {uart_ready_o, dbg_resp_valid_o});
    end
    cyc(); #1;
    n_checks++;
    if (uart_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rr_r3_c3: uart_ready got %b, expected 1", uart_ready_o);
    end
    dbg_resp_ready_i = 1'b0;
  endtask

  task automatic test_debug_read();
    cyc();
    core_wr_en_i = 1'b1; core_rd_i = 5'd3; core_wr_data_i = 32'hDEAD;
    exp_wr.push_back('{5'd3, 32'hDEAD});
    cyc();
    core_wr_en_i = 1'b0;
    dbg_valid_i = 1'b1; dbg_write_i = 1'b0; dbg_addr_i = 16'h1003; dbg_resp_ready_i = 1'b0;
    exp_resp.push_back('{32'hDEAD, 1'b0});
    #1;
    n_checks++;
    if (dbg_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rd_accept: dbg_ready got %b, expected 1", dbg_ready_o);
    end
    // The core overwrites x3 in the read cycle; the old value must come back.
    cyc();
    dbg_valid_i = 1'b0;
    core_wr_en_i = 1'b1; core_rd_i = 5'd3; core_wr_data_i = 32'hBEEF;
    exp_wr.push_back('{5'd3, 32'hBEEF});
    #1;
    n_checks++;
    if ({dbg_resp_valid_o, gpr_rd_addr_o} !== {1'b0, 5'd3}) begin
      n_fail++; $display("FAIL rd_wait: resp=%b rd_addr=%0d, expected resp=0 rd_addr=3",
                         dbg_resp_valid_o, gpr_rd_addr_o);
    end
    cyc();
    core_wr_en_i = 1'b0;
    #1;
    n_checks++;
    if ({dbg_resp_valid_o, dbg_rdata_o, dbg_err_o} !== {1'b1, 32'hDEAD, 1'b0}) begin
      n_fail++; $display("FAIL rd_latency: resp=%b rdata=%h err=%b, expected 1 0000dead 0",
                         dbg_resp_valid_o, dbg_rdata_o, dbg_err_o);
    end
    dbg_resp_ready_i = 1'b1;
    cyc();
    dbg_resp_ready_i = 1'b0;
    #1;
    n_checks++;
    if ({dbg_resp_valid_o, dbg_ready_o} !== 2'b01) begin
      n_fail++; $display("FAIL rd_done: resp/ready got %b, expected 01", {dbg_resp_valid_o, dbg_ready_o});
    end
    // Second read sees the core's write; then x0 reads as 0 despite raw junk.
    dbg_valid_i = 1'b1; dbg_addr_i = 16'h1003; dbg_resp_ready_i = 1'b1;
    exp_resp.push_back('{32'hBEEF, 1'b0});
    cyc(); dbg_valid_i = 1'b0;
    cyc(); cyc();
    dbg_valid_i = 1'b1; dbg_addr_i = 16'h1000;
    exp_resp.push_back('{32'h0, 1'b0});
    cyc(); dbg_valid_i = 1'b0;
    cyc(); cyc();
    dbg_resp_ready_i = 1'b0;
  endtask

  task automatic test_debug_err();
    dbg_valid_i = 1'b1; dbg_write_i = 1'b0; dbg_addr_i = 16'h0003;
    exp_resp.push_back('{32'h0, 1'b1});
    cyc();
    dbg_valid_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_checks++;
      if ({dbg_resp_valid_o, dbg_err_o, dbg_rdata_o, dbg_ready_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL err_hold c=%0d: resp=%b err=%b rdata=%h ready=%b, expected 1 1 0 0",
                 c, dbg_resp_valid_o, dbg_err_o, dbg_rdata_o, dbg_ready_o);
      end
      if (c == 3) dbg_resp_ready_i = 1'b1;
      else cyc();
    end
    cyc();
    dbg_resp_ready_i = 1'b0;
    #1;
    n_checks++;
    if ({dbg_resp_valid_o, dbg_ready_o} !== 2'b01) begin
      n_fail++; $display("FAIL err_done: resp/ready got %b, expected 01", {dbg_resp_valid_o, dbg_ready_o});
    end
  endtask

  task automatic test_x0_write();
    cyc();
    uart_valid_i = 1'b1; uart_rd_i = 5'd0; uart_data_i = 32'hFF;
    if (X0_WR_EN) exp_wr.push_back('{5'd0, 32'hFF});
    cyc();
    uart_valid_i = 1'b0;
    #1;
    n_checks++;
    if (gpr_wr_en_o !== X0_WR_EN) begin
      n_fail++; $display("FAIL x0_wr_en: got %b, expected %b", gpr_wr_en_o, X0_WR_EN);
    end
    cyc(); #1;
    n_checks++;
    if (uart_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL x0_ready: got %b, expected 1", uart_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc();
    core_wr_en_i = 1'b1; core_rd_i = 5'd5; core_wr_data_i = 32'hA5;
    uart_valid_i = 1'b1; uart_rd_i = 5'd13; uart_data_i = 32'h77;
    dbg_valid_i = 1'b1; dbg_write_i = 1'b1; dbg_addr_i = 16'h100E; dbg_wdata_i = 32'h88;
    exp_wr.push_back('{5'd5, 32'hA5});
    cyc();
    uart_valid_i = 1'b0; dbg_valid_i = 1'b0;
    exp_wr.push_back('{5'd5, 32'hA5});
    cyc();
    reg_rst = 1'b1;
    #1;
    n_checks++;
    if ({uart_ready_o, dbg_ready_o, core_stall_o, gpr_wr_en_o, dbg_resp_valid_o, dbg_err_o,
         gpr_wr_addr_o, gpr_wr_data_o} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: rdy=%b drdy=%b stall=%b wen=%b resp=%b wa=%0d, expected all 0",
               uart_ready_o, dbg_ready_o, core_stall_o, gpr_wr_en_o, dbg_resp_valid_o, gpr_wr_addr_o);
    end
    core_wr_en_i = 1'b0;
    cyc();
    reg_rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    n_checks++;
    if ({uart_ready_o, dbg_ready_o, dbg_resp_valid_o} !== 3'b110) begin
      n_fail++; $display("FAIL midrst_idle: got %b, expected 110", {uart_ready_o, dbg_ready_o, dbg_resp_valid_o});
    end
  endtask

  initial begin
    reg_rst = 1'b1;
    core_wr_en_i = 1'b0; core_rd_i = '0; core_wr_data_i = '0;
    uart_valid_i = 1'b0; uart_rd_i = '0; uart_data_i = '0;
    dbg_valid_i = 1'b0; dbg_write_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    dbg_resp_ready_i = 1'b0;

    test_reset();
    test_starvation();
    test_round_robin();
    test_debug_read();
    test_debug_err();
    test_x0_write();
    test_reset_mid();
    cyc();

    n_checks++;
    if (exp_wr.size() != 0) begin
      n_fail++; $display("FAIL wr_drain: %0d writes still expected, required 0", exp_wr.size());
    end
    n_checks++;
    if (exp_resp.size() != 0) begin
      n_fail++; $display("FAIL resp_drain: %0d responses still expected, required 0", exp_resp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
